// File: rtl/alu_pkg.sv
// Purpose : shared types and constants for the ALU round-robin scheduler.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: ALU opcode encodings, scheduler FSM state type, default widths.
package alu_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_OP_W   = 3;
    localparam int DEF_FLAG_W = 8;

    // Opcode encodings of the shared ALU; the scheduler forwards them untouched.
    localparam logic [2:0] ALU_ADD2C  = 3'b000;
    localparam logic [2:0] ALU_SUB2C  = 3'b001;
    localparam logic [2:0] ALU_ADDMAG = 3'b010;
    localparam logic [2:0] ALU_SUBMAG = 3'b011;
    localparam logic [2:0] ALU_ROTL   = 3'b100;
    localparam logic [2:0] ALU_ROTR   = 3'b101;
    localparam logic [2:0] ALU_DUP    = 3'b110;
    localparam logic [2:0] ALU_DIV    = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Purpose : round-robin pick of the first active request at or above ptr, with wrap.
// Latency : purely combinational.
// Backpressure: none; the caller decides whether the grant is honoured.
// Ports   : req (request vector), ptr (search start index),
//           grant (one-hot), grant_idx (binary index), any_req (some bit set).
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_req
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        idx       = 0;
        // Walk NUM_REQ positions starting at ptr; the first hit wins.
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!any_req && req[idx]) begin
                any_req     = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Purpose : shares one combinational ALU among NUM_REQ requesters, round-robin, tagged responses.
// Latency : request handshake in cycle N -> rsp_valid first high in cycle N+3; one op per 4 cycles max.
// Backpressure: response held stable until rsp_ready; no new request accepted until it is consumed.
// Ports   : req_valid/req_ready/req_op/req_a/req_b (flattened per requester),
//           rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_flags, alu_sel/alu_a/alu_b -> ALU,
//           alu_out/alu_flags <- ALU, busy (not IDLE), op_count (completed responses).
module alu_rr_scheduler
    import alu_pkg::*;
#(
    parameter int  NUM_REQ = 2,
    parameter int  DATA_W  = DEF_DATA_W,
    parameter int  OP_W    = DEF_OP_W,
    parameter int  FLAG_W  = DEF_FLAG_W,
    parameter int  CNT_W   = 16,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_result,
    output logic [FLAG_W-1:0]         rsp_flags,
    output logic [OP_W-1:0]           alu_sel,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    input  logic [DATA_W-1:0]         alu_out,
    input  logic [FLAG_W-1:0]         alu_flags,
    output logic                      busy,
    output logic [CNT_W-1:0]          op_count
);

    sched_state_t        state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     id_q;
    logic [ID_W-1:0]     grant_idx;
    logic [ID_W-1:0]     ptr_next;
    logic [NUM_REQ-1:0]  grant;
    logic                any_req;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    // Only IDLE can accept; grant is already zero when nobody is requesting.
    assign req_ready = (state == IDLE) ? grant : '0;
    assign busy      = (state != IDLE);

    // Explicit wrap so non-power-of-two NUM_REQ never lands on an unused index.
    assign ptr_next = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            id_q       <= '0;
            alu_sel    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        alu_sel <= req_op[int'(grant_idx)*OP_W +: OP_W];
                        alu_a   <= req_a[int'(grant_idx)*DATA_W +: DATA_W];
                        alu_b   <= req_b[int'(grant_idx)*DATA_W +: DATA_W];
                        id_q    <= grant_idx;
                        rr_ptr  <= ptr_next;
                        state   <= ISSUE;
                    end
                end
                // One full cycle with stable ALU inputs before sampling its outputs.
                ISSUE: state <= CAPTURE;
                CAPTURE: begin
                    rsp_result <= alu_out;
                    rsp_flags  <= alu_flags;
                    rsp_id     <= id_q;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Purpose : directed self-checking bench for alu_rr_scheduler with a stub ALU.
// Latency : n/a.
// Backpressure: exercises rsp_ready low while a response is pending.
module tb_alu_rr_scheduler;

    localparam int NR  = 2;
    localparam int CW  = 4;
    localparam int IDW = 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*3-1:0] req_op;
    logic [NR*8-1:0] req_a;
    logic [NR*8-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IDW-1:0]  rsp_id;
    logic [7:0]      rsp_result;
    logic [7:0]      rsp_flags;
    logic [2:0]      alu_sel;
    logic [7:0]      alu_a;
    logic [7:0]      alu_b;
    logic [7:0]      alu_out;
    logic [7:0]      alu_flags;
    logic            busy;
    logic [CW-1:0]   op_count;

    int checks = 0;
    int errors = 0;
    logic [CW-1:0] cnt_exp;

    always #5 clk = ~clk;

    alu_rr_scheduler #(.NUM_REQ(NR), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .alu_sel    (alu_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .alu_flags  (alu_flags),
        .busy       (busy),
        .op_count   (op_count)
    );

    // Stub ALU: characterised results for the directed vectors, a simple mix otherwise.
    function automatic logic [15:0] alu_stub(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        case ({s, a, b})
            {3'b000, 8'h23, 8'h56}: return {8'h79, 8'h02};
            {3'b000, 8'h56, 8'h79}: return {8'hCF, 8'h92};
            {3'b001, 8'h69, 8'h42}: return {8'h27, 8'h0B};
            {3'b111, 8'hFF, 8'h02}: return {8'h3F, 8'h09};
            {3'b110, 8'h01, 8'h05}: return {8'h20, 8'h00};
            default:                return {a + b + {5'd0, s}, a ^ b};
        endcase
    endfunction

    always_comb {alu_out, alu_flags} = alu_stub(alu_sel, alu_a, alu_b);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[i*3 +: 3] = op;
        req_a[i*8 +: 8]  = a;
        req_b[i*8 +: 8]  = b;
    endtask

    task automatic apply_reset();
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        cnt_exp = '0;
        tick();
    endtask

    // Issues one request on requester i (scheduler assumed idle) and waits, bounded, for its response.
    task automatic do_op(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic ok, output logic [7:0] res, output logic [7:0] flg);
        ok  = 1'b0;
        res = '0;
        flg = '0;
        rsp_ready = 1'b1;
        set_req(i, op, a, b);
        req_valid    = '0;
        req_valid[i] = 1'b1;
        tick();
        req_valid = '0;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid) begin
                ok  = 1'b1;
                res = rsp_result;
                flg = rsp_flags;
                break;
            end
            tick();
        end
        if (ok) tick();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
        checks++; if ({alu_sel, alu_a, alu_b} !== 19'd0) begin errors++; $display("FAIL reset_alu_regs got %h want 0", {alu_sel, alu_a, alu_b}); end
        checks++; if ({rsp_id, rsp_result, rsp_flags} !== 17'd0) begin errors++; $display("FAIL reset_rsp_regs got %h want 0", {rsp_id, rsp_result, rsp_flags}); end
        checks++; if (op_count !== 4'd0) begin errors++; $display("FAIL reset_op_count got %0d want 0", op_count); end
    endtask

    task automatic test_single_op();
        rsp_ready = 1'b1;
        set_req(0, 3'b000, 8'h23, 8'h56);
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_req_ready got %b want 01", req_ready); end
        tick();                                   // handshake edge N
        req_valid = '0;
        checks++; if ({alu_sel, alu_a, alu_b} !== {3'b000, 8'h23, 8'h56}) begin errors++; $display("FAIL single_alu_latch got %h want %h", {alu_sel, alu_a, alu_b}, {3'b000, 8'h23, 8'h56}); end
        checks++; if (busy !== 1'b1 || req_ready !== 2'b00) begin errors++; $display("FAIL single_busy got busy=%b rdy=%b want 1/00", busy, req_ready); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", rsp_valid); end
        tick();                                   // cycle N+3
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_latency got %b want 1", rsp_valid); end
        checks++; if ({rsp_id, rsp_result, rsp_flags} !== {1'b0, 8'h79, 8'h02}) begin errors++; $display("FAIL single_rsp got id=%0d res=%h flg=%h want 0/79/02", rsp_id, rsp_result, rsp_flags); end
        tick();
        cnt_exp = cnt_exp + 1'b1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done got vld=%b busy=%b want 0/0", rsp_valid, busy); end
        checks++; if (op_count !== cnt_exp) begin errors++; $display("FAIL single_op_count got %0d want %0d", op_count, cnt_exp); end
    endtask

    task automatic test_contention();
        apply_reset();
        set_req(0, 3'b000, 8'h56, 8'h79);
        set_req(1, 3'b001, 8'h69, 8'h42);
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL cont_first_grant got %b want 01", req_ready); end
        tick();
        req_valid = 2'b10;
        tick();
        tick();
        checks++; if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== {1'b1, 1'b0, 8'hCF, 8'h92}) begin errors++; $display("FAIL cont_rsp0 got vld=%b id=%0d res=%h flg=%h want 1/0/CF/92", rsp_valid, rsp_id, rsp_result, rsp_flags); end
        tick();
        cnt_exp = cnt_exp + 1'b1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL cont_second_grant got %b want 10", req_ready); end
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        checks++; if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== {1'b1, 1'b1, 8'h27, 8'h0B}) begin errors++; $display("FAIL cont_rsp1 got vld=%b id=%0d res=%h flg=%h want 1/1/27/0B", rsp_valid, rsp_id, rsp_result, rsp_flags); end
        tick();
        cnt_exp = cnt_exp + 1'b1;
        // Pointer is back at 0: requester 0 wins a fresh tie.
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL cont_ptr_wrap got %b want 01", req_ready); end
        req_valid = 2'b00;
        #1;
        checks++; if (op_count !== cnt_exp) begin errors++; $display("FAIL cont_op_count got %0d want %0d", op_count, cnt_exp); end
    endtask

    task automatic test_round_robin();
        logic seen;
        logic [7:0] exp_res;
        rsp_ready = 1'b1;
        set_req(0, 3'b010, 8'h10, 8'h01);
        set_req(1, 3'b011, 8'h20, 8'h02);
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            seen = 1'b0;
            for (int c = 0; c < 10; c++) begin
                tick();
                if (rsp_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (k == 5) req_valid = 2'b00;
            exp_res = (k % 2 == 0) ? 8'h13 : 8'h25;
            checks++; if (!seen) begin errors++; $display("FAIL rr_timeout op=%0d got no rsp_valid want rsp_valid", k); end
            checks++; if (rsp_id !== IDW'(k % 2)) begin errors++; $display("FAIL rr_id op=%0d got %0d want %0d", k, rsp_id, k % 2); end
            checks++; if (rsp_result !== exp_res) begin errors++; $display("FAIL rr_result op=%0d got %h want %h", k, rsp_result, exp_res); end
            cnt_exp = cnt_exp + 1'b1;
        end
        tick();
        tick();
        checks++; if (busy !== 1'b0 || op_count !== cnt_exp) begin errors++; $display("FAIL rr_end got busy=%b cnt=%0d want 0/%0d", busy, op_count, cnt_exp); end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        set_req(1, 3'b111, 8'hFF, 8'h02);
        req_valid = 2'b10;
        tick();
        req_valid = 2'b01;                        // a competing request must wait
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++; if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== {1'b1, 1'b1, 8'h3F, 8'h09}) begin errors++; $display("FAIL bp_hold cyc=%0d got vld=%b id=%0d res=%h flg=%h want 1/1/3F/09", c, rsp_valid, rsp_id, rsp_result, rsp_flags); end
            checks++; if (req_ready !== 2'b00 || op_count !== cnt_exp) begin errors++; $display("FAIL bp_stall cyc=%0d got rdy=%b cnt=%0d want 00/%0d", c, req_ready, op_count, cnt_exp); end
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        tick();
        cnt_exp = cnt_exp + 1'b1;
        checks++; if (rsp_valid !== 1'b0 || op_count !== cnt_exp) begin errors++; $display("FAIL bp_release got vld=%b cnt=%0d want 0/%0d", rsp_valid, op_count, cnt_exp); end
    endtask

    task automatic test_reset_mid_op();
        logic ok;
        logic [7:0] res;
        logic [7:0] flg;
        rsp_ready = 1'b1;
        set_req(0, 3'b000, 8'h23, 8'h56);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();                                   // now in CAPTURE
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, rsp_valid, req_ready} !== 4'b0000) begin errors++; $display("FAIL midrst_ctrl got busy=%b vld=%b rdy=%b want 0/0/00", busy, rsp_valid, req_ready); end
        checks++; if ({alu_sel, alu_a, alu_b, rsp_result, rsp_flags, op_count} !== 39'd0) begin errors++; $display("FAIL midrst_regs got %h want 0", {alu_sel, alu_a, alu_b, rsp_result, rsp_flags, op_count}); end
        tick();
        rst_n = 1'b1;
        cnt_exp = '0;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_stale cyc=%0d got vld=%b busy=%b want 0/0", c, rsp_valid, busy); end
        end
        do_op(0, 3'b110, 8'h01, 8'h05, ok, res, flg);
        cnt_exp = cnt_exp + 1'b1;
        checks++; if ({ok, res, flg} !== {1'b1, 8'h20, 8'h00}) begin errors++; $display("FAIL midrst_next got ok=%b res=%h flg=%h want 1/20/00", ok, res, flg); end
        checks++; if (op_count !== cnt_exp) begin errors++; $display("FAIL midrst_count got %0d want %0d", op_count, cnt_exp); end
    endtask

    task automatic test_counter_wrap();
        logic ok;
        logic [7:0] res;
        logic [7:0] flg;
        apply_reset();
        for (int k = 0; k < 17; k++) begin
            do_op(k % 2, 3'b000, 8'(k), 8'h01, ok, res, flg);
            checks++; if (ok !== 1'b1 || res !== 8'(k + 1)) begin errors++; $display("FAIL wrap_op k=%0d got ok=%b res=%h want 1/%h", k, ok, res, 8'(k + 1)); end
            if (k == 15) begin
                checks++; if (op_count !== 4'd0) begin errors++; $display("FAIL wrap_at16 got %0d want 0", op_count); end
            end
        end
        checks++; if (op_count !== 4'd1) begin errors++; $display("FAIL wrap_at17 got %0d want 1", op_count); end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        cnt_exp   = '0;
        test_reset();
        test_single_op();
        test_contention();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        test_counter_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
Shares one combinational 8-bit ALU (3-bit select, operands A/B, 8-bit result, 8-bit flags) between NUM_REQ requesters. Uses round-robin arbitration and a valid/ready request/response handshake. Registers the operands into the ALU, captures result and flags, and returns them tagged with the requester ID. Sits between the requester clients and the single ALU instance.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_W, 8, operand/result width
OP_W, 3, ALU select width
FLAG_W, 8, ALU flags width
CNT_W, 16, completed-operation counter width
ID_W, max(1,$clog2(NUM_REQ)), requester ID width (derived localparam)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_op  in  NUM_REQ*OP_W  flattened ALU select; requester i at [i*OP_W +: OP_W]
req_a  in  NUM_REQ*DATA_W  flattened operand A
req_b  in  NUM_REQ*DATA_W  flattened operand B
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_id  out  ID_W  requester index of the response
rsp_result  out  DATA_W  captured ALU result
rsp_flags  out  FLAG_W  captured ALU flags
alu_sel  out  OP_W  registered select to ALU
alu_a  out  DATA_W  registered operand A to ALU
alu_b  out  DATA_W  registered operand B to ALU
alu_out  in  DATA_W  ALU result (combinational from alu_*)
alu_flags  in  FLAG_W  ALU flags
busy  out  1  high in any state other than IDLE
op_count  out  CNT_W  completed (handshaked) responses

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n). All registers and outputs are 0 on reset: state=IDLE, rr_ptr=0, alu_sel/alu_a/alu_b=0, rsp_*=0, op_count=0.
- Reset mid-operation: any in-flight or pending response is discarded; no rsp_valid follows.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - grant = first asserted req_valid bit, searching upward from rr_ptr with wrap.
  - req_ready[grant]=1 combinationally; all other bits 0. No requests -> req_ready=0 and the FSM stays in IDLE.
  - On handshake: latch that requester's op/a/b into alu_sel/alu_a/alu_b, latch grant into id_q, set rr_ptr=(grant+1) mod NUM_REQ, go to ISSUE.
- req_ready is 0 in ISSUE, CAPTURE and RESP.
- ISSUE: ALU inputs stable for one full cycle (settling). -> CAPTURE.
- CAPTURE: at the clock edge, register alu_out->rsp_result, alu_flags->rsp_flags, id_q->rsp_id; set rsp_valid=1. -> RESP.
- RESP:
  - rsp_valid held high; rsp_result/rsp_flags/rsp_id held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid=0, op_count+=1 (wraps from 2^CNT_W-1 to 0), -> IDLE.
- Latency: request handshake at cycle N -> rsp_valid first high at cycle N+3. Maximum throughput with rsp_ready tied high is one op per 4 cycles.
- Ops are passed through unmodified, including div-by-zero and overflow; the flags carry their meaning.
- alu_sel/alu_a/alu_b keep their last value after the response; they are not cleared.
- req_valid deasserted without a handshake is legal; nothing is latched.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0.
- Requesters must hold op/a/b stable only in the handshake cycle.

Decomposition:
- Package alu_pkg:
  - opcode constants ALU_ADD2C=000, ALU_SUB2C=001, ALU_ADDMAG=010, ALU_SUBMAG=011, ALU_ROTL=100, ALU_ROTR=101, ALU_DUP=110, ALU_DIV=111.
  - typedef sched_state_t {IDLE,ISSUE,CAPTURE,RESP}.
  - DATA_W/OP_W/FLAG_W defaults.
- One sub-module rr_arbiter: combinational; inputs req vector and rr_ptr; outputs one-hot grant, grant index and any_req.

Test Plan:
- Single op: req0 op=000 A=23 B=56, rsp_ready=1 -> handshake at N, rsp_valid at N+3 with rsp_id=0, result=79, flags=02; op_count=1.
- Contention after reset: req0 (000 A=56 B=79) and req1 (001 A=69 B=42) valid in the same cycle -> req0 served first (CF/92), then req1 (27/0B) with id=1; rr_ptr=0 after the second grant.
- Round-robin: both requesters permanently valid for 6 ops -> rsp_id sequence 0,1,0,1,0,1; no starvation.
- Backpressure: rsp_ready=0 for 5 cycles in RESP with req1 op=111 A=FF B=02 -> rsp_valid/result 3F/flags 09 stable; req_ready stays 0; op_count unchanged until the handshake.
- Reset mid-op: assert rst_n=0 during CAPTURE -> all outputs 0 immediately (async); after release, no stale rsp_valid; next op req0 op=110 A=01 B=05 returns 20/00.
- Counter wrap: preload via CNT_W=4 override, complete 17 ops -> op_count=1.
